// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding, iterative-op kinds and flag bit positions for alu_mc.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_ORR  = 4'h3;
  localparam logic [3:0] OP_NOT  = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LSR  = 4'h6;
  localparam logic [3:0] OP_LSL  = 4'h7;
  localparam logic [3:0] OP_ADC  = 4'h8;
  localparam logic [3:0] OP_SBC  = 4'h9;
  localparam logic [3:0] OP_ASR  = 4'hA;
  localparam logic [3:0] OP_LSRV = 4'hB;
  localparam logic [3:0] OP_LSLV = 4'hC;
  localparam logic [3:0] OP_ROR  = 4'hD;
  localparam logic [3:0] OP_MUL  = 4'hE;
  localparam logic [3:0] OP_PASS = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    IT_ASR = 3'd0,
    IT_LSR = 3'd1,
    IT_LSL = 3'd2,
    IT_ROR = 3'd3,
    IT_MUL = 3'd4
  } iter_kind_e;

  localparam int unsigned FLAG_N = 0;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_P = 3;
  localparam int unsigned FLAG_W = 4;

endpackage

// File: rtl/alu_mc_if.sv
// Request/response handshake bundle between the control unit (master) and alu_mc (slave).
interface alu_mc_if #(
  parameter int unsigned WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             c_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] rd;
  logic             fN;
  logic             fZ;
  logic             fC;
  logic             fP;

  modport master (
    output in_valid, op, rs, rt, c_in, out_ready,
    input  in_ready, out_valid, rd, fN, fZ, fC, fP
  );

  modport slave (
    input  in_valid, op, rs, rt, c_in, out_ready,
    output in_ready, out_valid, rd, fN, fZ, fC, fP
  );

endinterface

// File: rtl/alu_iter.sv
// One-bit-per-cycle shift/rotate and shift-add multiply engine driven by alu_mc.
// The multiplier datapath exists only when ALU_MC_MUL_EN is defined.
module alu_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  iter_kind_e                 kind_i,
  input  logic [$clog2(WIDTH)-1:0]   n_i,
  input  logic [WIDTH-1:0]           rs_i,
`ifdef ALU_MC_MUL_EN
  input  logic [WIDTH-1:0]           rt_i,
`endif
  output logic                       busy_o,
  output logic                       done_c,
  output logic [WIDTH-1:0]           res_c,
  output logic                       carry_c
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;

  iter_kind_e       kind_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] step_d;
  logic             step_carry;

`ifdef ALU_MC_MUL_EN
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH:0]   sum;
`endif

  // One iteration step; the last step's value is handed straight to the result register.
  always_comb begin
    step_d     = work_q;
    step_carry = 1'b0;
`ifdef ALU_MC_MUL_EN
    acc_d = acc_q;
    sum   = '0;
`endif
    case (kind_q)
      IT_ASR: begin
        step_d     = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        step_carry = work_q[0];
      end
      IT_LSR: begin
        step_d     = {1'b0, work_q[WIDTH-1:1]};
        step_carry = work_q[0];
      end
      IT_LSL: begin
        step_d     = {work_q[WIDTH-2:0], 1'b0};
        step_carry = work_q[WIDTH-1];
      end
      IT_ROR: begin
        step_d     = {work_q[0], work_q[WIDTH-1:1]};
        step_carry = work_q[0];
      end
`ifdef ALU_MC_MUL_EN
      // {acc, work} is the running product; work starts as the multiplier.
      IT_MUL: begin
        sum        = {1'b0, acc_q} + (work_q[0] ? {1'b0, mcand_q} : (WIDTH+1)'(0));
        acc_d      = sum[WIDTH:1];
        step_d     = {sum[0], work_q[WIDTH-1:1]};
        step_carry = |sum[WIDTH:1];
      end
`endif
      default: begin
        step_d     = work_q;
        step_carry = 1'b0;
      end
    endcase
  end

  assign res_c   = step_d;
  assign carry_c = step_carry;
  assign done_c  = busy_q && (cnt_q == CW'(1));
  assign busy_o  = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      kind_q <= IT_ASR;
    end else if (start_i) begin
      busy_q <= 1'b1;
      kind_q <= kind_i;
`ifdef ALU_MC_MUL_EN
      if (kind_i == IT_MUL) begin
        work_q  <= rt_i;
        mcand_q <= rs_i;
        acc_q   <= '0;
        cnt_q   <= CW'(WIDTH);
      end else begin
        work_q <= rs_i;
        cnt_q  <= CW'(n_i);
      end
`else
      work_q <= rs_i;
      cnt_q  <= CW'(n_i);
`endif
    end else if (busy_q) begin
      work_q <= step_d;
`ifdef ALU_MC_MUL_EN
      acc_q  <= acc_d;
`endif
      cnt_q  <= cnt_q - CW'(1);
      if (done_c) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops computed at accept, shifts/rotates/multiply via alu_iter.
// Define ALU_MC_MUL_EN to enable opcode E as MUL; otherwise E behaves as PASS.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  alu_mc_if.slave  bus
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_e             state_q;
  logic [WIDTH-1:0]   rd_q;
  logic [FLAG_W-1:0]  flags_q;
  logic               in_ready_q;
  logic               out_valid_q;

  logic [WIDTH:0]     ext;
  logic [WIDTH-1:0]   sc_rd;
  logic               sc_c;
  logic               iter_sel;
  iter_kind_e         iter_kind;
  logic [SHW-1:0]     shamt;
  logic               accept;
  logic               iter_start;
  logic               iter_busy;
  logic               iter_done;
  logic [WIDTH-1:0]   iter_res;
  logic               iter_carry;

  function automatic logic [FLAG_W-1:0] mk_flags(input logic [WIDTH-1:0] r, input logic c);
    logic [FLAG_W-1:0] f;
    f         = '0;
    f[FLAG_N] = r[WIDTH-1];
    f[FLAG_Z] = (r == '0);
    f[FLAG_C] = c;
    f[FLAG_P] = ~r[0];
    return f;
  endfunction

  assign shamt = bus.rt[SHW-1:0];

  // Single-cycle results and iterative-op routing; a zero shift amount completes immediately.
  always_comb begin
    ext       = '0;
    sc_rd     = bus.rs;
    sc_c      = 1'b0;
    iter_sel  = 1'b0;
    iter_kind = IT_ASR;
    case (bus.op)
      OP_ADD: begin
        ext           = {1'b0, bus.rs} + {1'b0, bus.rt};
        {sc_c, sc_rd} = ext;
      end
      OP_SUB: begin
        ext           = {1'b0, bus.rs} - {1'b0, bus.rt};
        {sc_c, sc_rd} = ext;
      end
      OP_AND: sc_rd = bus.rs & bus.rt;
      OP_ORR: sc_rd = bus.rs | bus.rt;
      OP_NOT: sc_rd = ~bus.rs;
      OP_XOR: sc_rd = bus.rs ^ bus.rt;
      OP_LSR: begin
        sc_rd = bus.rs >> 1;
        sc_c  = bus.rs[0];
      end
      OP_LSL: begin
        sc_rd = bus.rs << 1;
        sc_c  = bus.rs[0];
      end
      OP_ADC: begin
        ext           = {1'b0, bus.rs} + {1'b0, bus.rt} + (WIDTH+1)'(bus.c_in);
        {sc_c, sc_rd} = ext;
      end
      OP_SBC: begin
        ext           = {1'b0, bus.rs} - {1'b0, bus.rt} - (WIDTH+1)'(bus.c_in);
        {sc_c, sc_rd} = ext;
      end
      OP_ASR: begin
        iter_sel  = (shamt != '0);
        iter_kind = IT_ASR;
      end
      OP_LSRV: begin
        iter_sel  = (shamt != '0);
        iter_kind = IT_LSR;
      end
      OP_LSLV: begin
        iter_sel  = (shamt != '0);
        iter_kind = IT_LSL;
      end
      OP_ROR: begin
        iter_sel  = (shamt != '0);
        iter_kind = IT_ROR;
      end
`ifdef ALU_MC_MUL_EN
      OP_MUL: begin
        iter_sel  = 1'b1;
        iter_kind = IT_MUL;
      end
`endif
      default: sc_rd = bus.rs;
    endcase
  end

  assign accept     = bus.in_valid && in_ready_q;
  assign iter_start = (state_q == ST_IDLE) && accept && iter_sel;

  alu_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk     (clk),
    .rst     (rst),
    .start_i (iter_start),
    .kind_i  (iter_kind),
    .n_i     (shamt),
    .rs_i    (bus.rs),
`ifdef ALU_MC_MUL_EN
    .rt_i    (bus.rt),
`endif
    .busy_o  (iter_busy),
    .done_c  (iter_done),
    .res_c   (iter_res),
    .carry_c (iter_carry)
  );

  // Control FSM; result and flags load only on the cycle that raises out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rd_q        <= '0;
      flags_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            if (iter_sel) begin
              state_q <= ST_ITER;
            end else begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              rd_q        <= sc_rd;
              flags_q     <= mk_flags(sc_rd, sc_c);
            end
          end
        end
        ST_ITER: begin
          if (iter_busy && iter_done) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            rd_q        <= iter_res;
            flags_q     <= mk_flags(iter_res, iter_carry);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.rd        = rd_q;
  assign bus.fN        = flags_q[FLAG_N];
  assign bus.fZ        = flags_q[FLAG_Z];
  assign bus.fC        = flags_q[FLAG_C];
  assign bus.fP        = flags_q[FLAG_P];

endmodule

// File: tb/tb_alu_mc.sv
// Randomized and directed bench for alu_mc (WIDTH=16) against an arithmetic reference model.
// Opcode E expectations follow ALU_MC_MUL_EN.
module tb_alu_mc;

  localparam int unsigned W = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  alu_mc_if #(.WIDTH(W)) bus ();

  alu_mc #(.WIDTH(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the opcode table.
  function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                input logic ci, output logic [15:0] r, output logic c,
                                output int lat);
    int               n;
    int               ia;
    int               ib;
    logic [31:0]      wide;
    logic signed [15:0] sa;
    n    = int'(b[3:0]);
    ia   = int'(a);
    ib   = int'(b);
    sa   = a;
    r    = a;
    c    = 1'b0;
    lat  = 1;
    wide = '0;
    case (op)
      4'h0: begin r = 16'(ia + ib);             c = (ia + ib) > 65535; end
      4'h1: begin r = 16'(ia - ib);             c = ia < ib; end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = ~a;
      4'h5: r = a ^ b;
      4'h6: begin r = a >> 1;                   c = a[0]; end
      4'h7: begin r = a << 1;                   c = a[0]; end
      4'h8: begin r = 16'(ia + ib + int'(ci));  c = (ia + ib + int'(ci)) > 65535; end
      4'h9: begin r = 16'(ia - ib - int'(ci));  c = ia < (ib + int'(ci)); end
      4'hA: begin r = 16'(sa >>> n);            c = (n > 0) ? a[n-1] : 1'b0; lat = n + 1; end
      4'hB: begin r = a >> n;                   c = (n > 0) ? a[n-1] : 1'b0; lat = n + 1; end
      4'hC: begin r = a << n;                   c = (n > 0) ? a[16-n] : 1'b0; lat = n + 1; end
      4'hD: begin
        r   = (n > 0) ? ((a >> n) | (a << (16 - n))) : a;
        c   = (n > 0) ? a[n-1] : 1'b0;
        lat = n + 1;
      end
`ifdef ALU_MC_MUL_EN
      4'hE: begin
        wide = 32'(ia) * 32'(ib);
        r    = wide[15:0];
        c    = (wide[31:16] != 16'h0);
        lat  = 17;
      end
`endif
      default: r = a;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input int hold);
    logic [15:0] er;
    logic        ec;
    int          el;
    int          lat;
    logic [3:0]  ef;
    model(op, a, b, ci, er, ec, el);
    ef = {er[15], (er == 16'h0), ec, ~er[0]};
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.rs       = a;
    bus.rt       = b;
    bus.c_in     = ci;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op       = 4'($urandom);
    bus.rs       = 16'($urandom);
    bus.rt       = 16'($urandom);
    bus.c_in     = 1'($urandom);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(el));
    chk("rd", 32'(bus.rd), 32'(er));
    chk("flags", 32'({bus.fN, bus.fZ, bus.fC, bus.fP}), 32'(ef));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_rd", 32'(bus.rd), 32'(er));
      chk("bp_flags", 32'({bus.fN, bus.fZ, bus.fC, bus.fP}), 32'(ef));
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("ret_ready", 32'(bus.in_ready), 32'd1);
    chk("ret_valid", 32'(bus.out_valid), 32'd0);
    chk("held_rd", 32'(bus.rd), 32'(er));
    chk("held_flags", 32'({bus.fN, bus.fZ, bus.fC, bus.fP}), 32'(ef));
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 4'h0;
    bus.rs        = '0;
    bus.rt        = '0;
    bus.c_in      = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_rd", 32'(bus.rd), 32'd0);
    chk("rst_flags", 32'({bus.fN, bus.fZ, bus.fC, bus.fP}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(4'h0, 16'hFFFF, 16'h0001, 1'b0, 0);
    run_op(4'h1, 16'h0003, 16'h0005, 1'b0, 0);
    run_op(4'h9, 16'h0010, 16'h0001, 1'b1, 0);
    run_op(4'hA, 16'h8010, 16'h0004, 1'b0, 0);
    run_op(4'hD, 16'h0001, 16'h0001, 1'b0, 0);
    run_op(4'hC, 16'hABCD, 16'h0000, 1'b0, 0);
    run_op(4'hE, 16'h0123, 16'h0010, 1'b0, 0);
    run_op(4'hE, 16'h0100, 16'h0100, 1'b0, 0);
    run_op(4'hE, 16'h1234, 16'h0000, 1'b0, 0);
    run_op(4'h8, 16'h7FFF, 16'h0000, 1'b1, 3);
    run_op(4'hB, 16'hF00F, 16'h000F, 1'b0, 3);
    run_op(4'h6, 16'h0003, 16'h0000, 1'b0, 1);
    run_op(4'h7, 16'h8002, 16'h0000, 1'b0, 1);

    for (int k = 0; k < 80; k++) begin
      run_op(4'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    // Reset during the 5th cycle of a long iterative op discards it.
    run_op(4'h0, 16'h0001, 16'h0002, 1'b0, 0);
    @(negedge clk);
    bus.in_valid = 1'b1;
`ifdef ALU_MC_MUL_EN
    bus.op = 4'hE;
    bus.rs = 16'h1357;
    bus.rt = 16'h2468;
`else
    bus.op = 4'hA;
    bus.rs = 16'h8000;
    bus.rt = 16'h000F;
`endif
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_rd", 32'(bus.rd), 32'd0);
    chk("mid_rst_flags", 32'({bus.fN, bus.fZ, bus.fC, bus.fP}), 32'd0);
    rst = 1'b0;
    run_op(4'h0, 16'h0001, 16'h0001, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Multi-cycle, width-parametrised successor to the 16-bit combinational ALU.
- Executes the same eight base operations in one cycle.
- Adds carry-chained arithmetic, variable-amount shifts/rotate and an optional iterative multiply.
- Uses a valid/ready handshake and registered result and flags.
- Sits between the register-file read stage and writeback; the control unit stalls on in_ready/out_valid.

Parameters:
- WIDTH, 16, data width in bits (≥4, power of 2); SHW = $clog2(WIDTH) is a derived localparam.

Ports:
- clk  in  1  clock, rising-edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operation request
- in_ready  out  1  block can accept (high only in IDLE)
- op  in  4  opcode
- rs  in  WIDTH  operand Rs
- rt  in  WIDTH  operand Rt; for variable shifts, the shift amount is rt[SHW-1:0]
- c_in  in  1  carry/borrow in for ADC/SBC
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- rd  out  WIDTH  result
- fN, fZ, fC, fP  out  1 each  negative, zero, carry/borrow, even-parity (fP = ~rd[0])

Behaviour:
- Interface: one clock (clk); reset synchronous, active-high (rst).
- Reset: state=IDLE; rd=0, all flags=0, out_valid=0, in_ready=1. Reset wins over every other event, including mid-operation; partial work is discarded.
- Accept: an operation is accepted when in_valid && in_ready. Operands and op are latched; inputs are don't-care afterwards.
- States and transitions:
  - IDLE -> DONE for single-cycle ops.
  - IDLE -> ITER for iterative ops.
  - ITER -> DONE when the count expires.
  - DONE -> IDLE when out_ready.
- Single-cycle ops (out_valid the cycle after accept):
  - 0 ADD: {C,rd} = rs + rt.
  - 1 SUB: {C,rd} = {0,rs} − {0,rt}; C=1 means borrow.
  - 2 AND, 3 ORR, 5 XOR: C=0.
  - 4 NOT: ~rs, C=0.
  - 6 LSR, 7 LSL: shift by 1; C = rs[0] for both (legacy rule kept).
  - 8 ADC: rs + rt + c_in.
  - 9 SBC: rs − rt − c_in; C=borrow.
  - F PASS: rd = rs, C=0.
- Iterative ops (one bit per cycle, in ITER):
  - A ASR, B LSRV, C LSLV, D ROR, each by n = rt[SHW-1:0].
  - C = last bit shifted or rotated out; n=0 -> rd=rs, C=0.
  - Latency n+1 cycles from accept to out_valid (n=0 -> 1).
  - E MUL: shift-add. rd = low WIDTH bits of rs*rt; C=1 if the high half ≠ 0. Latency WIDTH+1.
- Flags: computed from the final rd. fN = rd[WIDTH-1]; fZ = (rd==0); fP = ~rd[0].
- Register update: rd and flags update only on the cycle out_valid rises, and are held otherwise, including after DONE->IDLE until the next completion.
- Backpressure: in DONE with out_ready low, out_valid stays high and rd/flags stay stable; in_ready stays low.
- Throughput: one op per 2 cycles minimum. No accept in the same cycle as out_valid&&out_ready.
- Counter: the iteration counter is SHW+1 bits and never wraps. MUL counts WIDTH steps exactly.

Optional Feature:
- Macro: ALU_MC_MUL_EN.
- Defined: opcode E performs MUL as above.
- Undefined: the multiplier datapath is omitted. Opcode E behaves as PASS (rd=rs, C=0, latency 1).

Decomposition:
- alu_pkg holds:
  - 4-bit opcode localparams (OP_ADD..OP_PASS).
  - State encodings (IDLE, ITER, DONE).
  - Flag bit indices.
- Sub-module alu_iter holds the iterative shift/rotate/multiply datapath and counter, with a start/busy/done interface to the alu_mc control FSM. Single-cycle ops stay in alu_mc.

Test Plan:
- ADD 0xFFFF + 0x0001 -> rd=0x0000, C=1, Z=1, N=0, P=1, out_valid one cycle after accept.
- SUB 0x0003 − 0x0005 -> rd=0xFFFE, C=1, N=1, Z=0, P=1; SBC 0x0010 − 0x0001 with c_in=1 -> rd=0x000E, C=0.
- ASR 0x8010 by rt=4 -> rd=0xF801, C=0, out_valid at accept+5. ROR 0x0001 by 1 -> 0x8000, C=1. LSLV by rt=0 -> rd=rs, C=0, latency 1.
- MUL 0x0123 * 0x0010 -> 0x1230, C=0, latency 17. MUL 0x0100 * 0x0100 -> 0x0000, C=1, Z=1. Without ALU_MC_MUL_EN, op E rs=0x1234 -> 0x1234 at latency 1.
- Backpressure: hold out_ready low 3 cycles after completion -> out_valid, rd and flags stable, in_ready=0. Raise out_ready -> in_ready=1 the next cycle.
- Assert rst on the 5th cycle of a MUL -> the next cycle shows in_ready=1, out_valid=0, rd=0, flags=0. A following ADD 1+1 yields 0x0002 correctly.
